// File: rtl/riscv_pkg.sv
// ============================================================================
//  riscv_pkg
//  Shared core types and constants for the RISC-V fetch path.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic            err;
    } imem_rsp_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  sync_fifo
//  First-word-fall-through FIFO with extra-bit pointers; no push-side ready.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty    = (wr_ptr_q == rd_ptr_q);
    // Head is forced to zero when empty so the output is clean out of reset.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (PW+1)'(push);
        rd_ptr_d = rd_ptr_q + (PW+1)'(pop && !empty);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/imem_responder.sv
// ============================================================================
//  imem_responder
//  Memory side of the fetch interface: fixed-latency read, in-order credited responses.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module imem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic                     rsp_err,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic      valid;
        imem_rsp_t rsp;
    } stage_t;

    logic [XLEN-1:0] mem [DEPTH];
    stage_t          stage_q [LATENCY];
    stage_t          stage_d [LATENCY];
    logic [CW-1:0]   outstanding_q, outstanding_d;

    logic      accept;
    logic      handshake;
    logic      addr_err;
    logic      fifo_empty;
    imem_rsp_t fifo_head;

    // Credit check uses only the registered count, never req_valid.
    assign req_ready = (outstanding_q < CW'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;
    assign handshake = rsp_valid && rsp_ready;
    assign addr_err  = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH));

    assign rsp_valid = !fifo_empty;
    assign rsp_data  = fifo_head.data;
    assign rsp_err   = fifo_head.err;

    always_ff @(posedge i_clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        case ({accept, handshake})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        // Stage 0 samples the array before any same-edge load lands.
        stage_d[0].valid    = accept;
        stage_d[0].rsp.err  = addr_err;
        stage_d[0].rsp.data = addr_err ? NOP_INSN : mem[req_addr[2 +: AW]];
        for (int i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            outstanding_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            outstanding_q <= outstanding_d;
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(imem_rsp_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push      (stage_q[LATENCY-1].valid),
        .push_data (stage_q[LATENCY-1].rsp),
        .pop       (handshake),
        .pop_data  (fifo_head),
        .empty     (fifo_empty)
    );

endmodule

`default_nettype wire
